// File: rtl/thread_fetch.sv
// Two-thread round-robin instruction fetch stage with a single output register.
// Optional prefix fusion is enabled by defining FETCH_PRE_FUSE_EN.
module thread_fetch (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_inst,
    output logic [15:0] out_pc,
    output logic        out_tid,
    output logic [3:0]  out_pre,
    input  logic        redirect_valid,
    input  logic        redirect_tid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    input  logic        halt_tid,
    output logic        halted
);

    // Output handshake: an entry transfers on out_valid && out_ready; the
    // register may be reloaded whenever it is empty or being drained.
    logic [1:0][15:0] pc;
    logic [1:0]       hflag;
    logic             sel;

    logic       free;
    logic       ftid;
    logic       fetch;
    logic [1:0] halt_hit;
    logic [1:0] redir_hit;
    logic       kill;
    logic       is_pre;
    logic       emit;

    always_comb begin
        free      = !out_valid || out_ready;
        ftid      = hflag[sel] ? ~sel : sel;
        fetch     = free && !hflag[ftid];
        imem_addr = pc[ftid];
        halt_hit  = 2'b00;
        if (halt_req) halt_hit[halt_tid] = 1'b1;
        redir_hit = 2'b00;
        if (redirect_valid) redir_hit[redirect_tid] = 1'b1;
        // Halted threads ignore redirects, and a same-cycle halt wins.
        redir_hit = redir_hit & ~hflag & ~halt_hit;
        kill      = halt_hit[ftid] || redir_hit[ftid];
        emit      = fetch && !kill && !is_pre;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= {16'h0001, 16'h0000};
            hflag     <= 2'b00;
            sel       <= 1'b0;
            halted    <= 1'b0;
            out_valid <= 1'b0;
            out_inst  <= 16'h0000;
            out_pc    <= 16'h0000;
            out_tid   <= 1'b0;
        end else begin
            for (int t = 0; t < 2; t++) begin
                if (redir_hit[t])
                    pc[t] <= redirect_pc;
                else if (fetch && ftid == t[0] && !halt_hit[t])
                    pc[t] <= pc[t] + 16'd2;
            end
            hflag  <= hflag | halt_hit;
            halted <= halted | (&hflag);
            if (fetch) sel <= ~ftid;
            if (free) begin
                out_valid <= emit;
                if (emit) begin
                    out_inst <= imem_rdata;
                    out_pc   <= pc[ftid];
                    out_tid  <= ftid;
                end
            end else if (redir_hit[out_tid]) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PRE_FUSE_EN
    logic [1:0][3:0] pend;
    logic [3:0]      pre_q;

    assign is_pre  = (imem_rdata[15:12] == 4'hF);
    assign out_pre = pre_q;

    // A pending prefix of zero is indistinguishable from no prefix.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend  <= '0;
            pre_q <= 4'h0;
        end else begin
            for (int t = 0; t < 2; t++) begin
                if (halt_hit[t] || redir_hit[t])
                    pend[t] <= 4'h0;
                else if (fetch && ftid == t[0])
                    pend[t] <= is_pre ? imem_rdata[3:0] : 4'h0;
            end
            if (emit) pre_q <= pend[ftid];
        end
    end
`else
    assign is_pre  = 1'b0;
    assign out_pre = 4'h0;
`endif

endmodule

// File: tb/tb_thread_fetch.sv
// Self-checking bench for thread_fetch: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_thread_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic        out_tid;
    logic [3:0]  out_pre;
    logic        redirect_valid = 1'b0;
    logic        redirect_tid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt_req = 1'b0;
    logic        halt_tid = 1'b0;
    logic        halted;

    logic [15:0] mem [0:65535];
    assign imem_rdata = mem[imem_addr];

    thread_fetch dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_ready(out_ready), .out_valid(out_valid), .out_inst(out_inst),
        .out_pc(out_pc), .out_tid(out_tid), .out_pre(out_pre),
        .redirect_valid(redirect_valid), .redirect_tid(redirect_tid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .halt_tid(halt_tid),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    // Reference model state
    logic [15:0] m_pc [2];
    logic [3:0]  m_pend [2];
    bit          m_h [2];
    int          m_sel;
    bit          m_halted;
    bit          m_valid;
    logic [15:0] m_inst;
    logic [15:0] m_opc;
    bit          m_tid;
    logic [3:0]  m_pre;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick();
        if (!m_h[m_sel]) return m_sel;
        if (!m_h[1 - m_sel]) return 1 - m_sel;
        return -1;
    endfunction

    task automatic model_reset();
        m_pc[0] = 16'h0000; m_pc[1] = 16'h0001;
        m_pend[0] = 4'h0; m_pend[1] = 4'h0;
        m_h[0] = 1'b0; m_h[1] = 1'b0;
        m_sel = 0; m_halted = 1'b0; m_valid = 1'b0;
        m_inst = 16'h0; m_opc = 16'h0; m_tid = 1'b0; m_pre = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        out_ready = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_inst", out_inst, 16'h0);
        check("rst_pc", out_pc, 16'h0);
        check("rst_tid", 16'(out_tid), 16'h0);
        check("rst_pre", 16'(out_pre), 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock: drive inputs, advance the model by the fetch rules, compare.
    task automatic step(input bit rdy, input bit rv, input bit rt, input logic [15:0] rpc,
                        input bit hr, input bit ht);
        int t;
        bit free, disc, pre, nxt_halted;
        bit hh [2];
        bit hrr [2];
        logic [15:0] w;
        out_ready = rdy; redirect_valid = rv; redirect_tid = rt; redirect_pc = rpc;
        halt_req = hr; halt_tid = ht;
        #1;
        t = pick();
        if (t >= 0) check("imem_addr", imem_addr, m_pc[t]);
        for (int i = 0; i < 2; i++) begin
            hh[i]  = hr && (int'(ht) == i);
            hrr[i] = rv && (int'(rt) == i) && !m_h[i] && !hh[i];
        end
        free = !m_valid || rdy;
        nxt_halted = m_halted || (m_h[0] && m_h[1]);
        if (free) begin
            m_valid = 1'b0;
            if (t >= 0) begin
                w = mem[m_pc[t]];
                disc = hh[t] || hrr[t];
                pre = 1'b0;
`ifdef FETCH_PRE_FUSE_EN
                pre = (w[15:12] == 4'hF);
`endif
                m_sel = 1 - t;
                if (!disc) begin
                    if (pre) begin
                        m_pend[t] = w[3:0];
                    end else begin
                        m_valid = 1'b1; m_inst = w; m_opc = m_pc[t];
                        m_tid = (t == 1); m_pre = m_pend[t]; m_pend[t] = 4'h0;
                    end
                    m_pc[t] = m_pc[t] + 16'd2;
                end
            end
        end else if (hrr[m_tid]) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (hrr[i]) m_pc[i] = rpc;
            if (hh[i] || hrr[i]) m_pend[i] = 4'h0;
            if (hh[i]) m_h[i] = 1'b1;
        end
        m_halted = nxt_halted;
        @(posedge clk);
        @(negedge clk);
        check("out_valid", 16'(out_valid), 16'(m_valid));
        check("halted", 16'(halted), 16'(m_halted));
        if (m_valid) begin
            check("out_inst", out_inst, m_inst);
            check("out_pc", out_pc, m_opc);
            check("out_tid", 16'(out_tid), 16'(m_tid));
            check("out_pre", 16'(out_pre), 16'(m_pre));
        end
    endtask

    task automatic go(input bit rdy);
        step(rdy, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom) & 16'h7FFF;
        mem[0] = 16'h1001; mem[1] = 16'h2002; mem[2] = 16'h3003;
        model_reset();
        do_reset();

        // Basic alternation, then a held entry and release.
        go(1'b1);
        check("r031_e0", {out_tid, out_pc[14:0]}, 16'h0000);
        check("r031_e0_inst", out_inst, 16'h1001);
        go(1'b1);
        check("r031_e1", out_pc, 16'h0001);
        check("r031_e1_tid", 16'(out_tid), 16'h1);
        for (int i = 0; i < 3; i++) go(1'b0);
        check("r032_hold_pc", out_pc, 16'h0001);
        go(1'b1);
        check("r032_rel_pc", out_pc, 16'h0002);
        check("r032_rel_inst", out_inst, 16'h3003);

        // Redirect squashes a held tid1 entry.
        go(1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h0041, 1'b0, 1'b0);
        check("r033_squash", 16'(out_valid), 16'h0);
        go(1'b1);
        go(1'b1);
        check("r033_target", out_pc, 16'h0041);

        // Redirect tid1 to the top of memory wraps to 0x0001.
        do_reset();
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0001);
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            go(1'b1);
            if (out_valid && out_tid && exp_q.size() > 0) check("r036_wrap", out_pc, exp_q.pop_front());
        end
        check("r036_drain", 16'(exp_q.size()), 16'h0);

        // Halt thread 0, then thread 1.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            go(1'b1);
            check("r034_only_t1", 16'({out_valid, out_tid}), 16'h3);
        end
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        go(1'b1);
        check("r034_halted", 16'(halted), 16'h1);
        check("r034_idle", 16'(out_valid), 16'h0);

        // Prefix word handling.
        do_reset();
        mem[0] = 16'hF00A; mem[2] = 16'h6123;
`ifdef FETCH_PRE_FUSE_EN
        go(1'b1);
        go(1'b1);
        go(1'b1);
        check("r035_inst", out_inst, 16'h6123);
        check("r035_pc", out_pc, 16'h0002);
        check("r035_pre", 16'(out_pre), 16'h000A);
`else
        go(1'b1);
        check("r035_inst", out_inst, 16'hF00A);
        check("r035_pre", 16'(out_pre), 16'h0000);
`endif

        // Randomized traffic with mid-stream resets.
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) mem[i][15:12] = 4'hF;
        end
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                     1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                     $urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
